gpr_writeback_arbiter: RTL and testbench
========================================

# gpr_writeback_arbiter

Shares the register file's single GPR write port (`i_load_gpr` / `i_load_gpr_sel` / `i_load_gpr_data`) among several writeback requesters, such as the ALU, load unit and CSR unit. Requesters use a valid/ready handshake and are granted in round-robin order. The winning write is driven to the register file from registered outputs. A 31-entry pending-write scoreboard tracks which destination registers have an issued-but-uncommitted write, so the issue stage can stall on RAW hazards.

## Interface
Parameters:
- `N_REQ`, default 3: number of writeback requesters (2..8).
- `XLEN`, default 32: data width.
- `L2_NREG`, default 5: register select width.

Ports:
- `i_clk`  in  1: clock; positive edge used.
- `i_rst`  in  1: reset, synchronous, active-high.
- `i_req_valid`  in  N_REQ: requester k has a write pending.
- `i_req_sel`  in  N_REQ×L2_NREG: destination register of requester k.
- `i_req_data`  in  N_REQ×XLEN: write data of requester k.
- `o_req_ready`  out  N_REQ: one-hot grant; handshake completes on `valid & ready` at a clock edge.
- `o_load_gpr`  out  1: write strobe to the register file.
- `o_load_gpr_sel`  out  L2_NREG: register select to the register file.
- `o_load_gpr_data`  out  XLEN: write data to the register file.
- `i_reserve`  in  1: issue stage marks a destination as pending.
- `i_reserve_sel`  in  L2_NREG: register being reserved.
- `o_busy`  out  2^L2_NREG: bit r set means register r has an outstanding write; bit 0 is always 0.

## Operation
- Round-robin arbitration:
  - Pointer `prio` (0..N_REQ-1) names the highest-priority requester.
  - Grant goes to the first valid requester scanning `prio`, `prio+1`, … modulo N_REQ.
  - After a grant to k, `prio` becomes (k+1) mod N_REQ. With no grant, `prio` holds.
- `o_req_ready` is combinational from `i_req_valid` and `prio`. It is at most one-hot and 0 for non-valid requesters. Requesters must not make `valid` depend on `ready`.
- A requester must hold `sel` and `data` stable while `valid` is high and not yet granted.
- On a handshake, the output register captures sel and data. `o_load_gpr` is set only if sel ≠ 0; writes to r0 complete the handshake but are dropped.
- Scoreboard update each edge:
  - Clear bit `o_load_gpr_sel` if `o_load_gpr` is high.
  - Then set bit `i_reserve_sel` if `i_reserve` is high and sel ≠ 0.
  - Set wins over clear for the same register in the same cycle.
- Reserving an already-busy register is legal; the bit stays set. There is no counting: the next commit to that register clears it.
- No internal queue. The write port is never back-pressured, so one grant is possible every cycle.

## Timing
- Handshake at edge E → `o_load_gpr`/sel/data valid in the cycle after E → register file writes at edge E+1 → data readable combinationally after E+1.
- The `o_busy` bit clears at edge E+1, the same edge as the register file write. An issue stage sampling `o_busy` after E+1 sees the register free and reads the new value.
- Sustained throughput: 1 write/cycle. Latency from handshake edge to committed data: 1 cycle.
- Reset (`i_rst` high at an edge):
  - `o_load_gpr`=0, `o_load_gpr_sel`=0, `o_load_gpr_data`=0, `prio`=0, `o_busy`=0.
  - `o_req_ready`=0 while `i_rst` is high.
  - A write registered but not yet committed when reset is sampled is dropped.
- Simultaneous events:
  - All requesters valid: strict rotation 0,1,2,0,…
  - A requester that drops `valid` is skipped without penalty.

## Structure
- Shared package `core_pkg`: `XLEN`, `L2_NREG`, and a `wb_req_t` struct (`valid`, `sel`, `data`) for requester bundles.
- One sub-module `rr_arbiter`: parameterised N-way round-robin, with `i_clk`, `i_rst`, `i_req[N]`, `o_grant[N]`, and an internal pointer update on grant. Reused later for memory-port sharing.
- The top level holds the output register and scoreboard.

## Test plan
- Reset: set `o_busy`=all-ones-equivalent by reserves, assert `i_rst` one cycle → `o_busy`=0, `o_load_gpr`=0, `o_req_ready`=0 during reset, `prio`=0 (next all-valid grant goes to requester 0).
- Rotation: N_REQ=3, all valid continuously with sel 5/6/7 → grants 0,1,2,0,1,2; `o_load_gpr_sel` 5,6,7,5,… one cycle after each grant.
- r0 write: requester 1 valid, sel=0, data=0xDEADBEEF → `o_req_ready[1]`=1, `o_load_gpr` stays 0 next cycle.
- Scoreboard: reserve r3, then requester 0 writes r3=0x1234 → `o_busy[3]`=1 until the commit edge, 0 after. The register file model reads 0x1234.
- Same-cycle set/clear: while r9's write commits, reserve r9 → `o_busy[9]` remains 1.
- Reset mid-operation: handshake for r4 at edge E, `i_rst` high at E+1 → r4 not written, `o_load_gpr`=0 after E+1.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types and widths for the writeback path and other port sharers.
package core_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned L2_NREG = 5;
  localparam int unsigned NREG    = 1 << L2_NREG;

  typedef struct packed {
    logic               valid;
    logic [L2_NREG-1:0] sel;
    logic [XLEN-1:0]    data;
  } wb_req_t;

  // Pointer width for an n-way arbiter; a 1-way arbiter still needs one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: grant is combinational from requests and the
// priority pointer; the pointer moves just past the winner on every grant.
module rr_arbiter
  import core_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_grant
);

  localparam int unsigned PW = ptr_width(N);

  logic [PW-1:0] prio;
  logic [PW-1:0] gnt_idx;
  logic [PW:0]   idx;
  logic          found;

  // Scan from prio upward, wrapping modulo N; first requester seen wins.
  always_comb begin
    o_grant = '0;
    found   = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    if (!i_rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        idx = {1'b0, prio} + (PW+1)'(i);
        if (idx >= (PW+1)'(N)) begin
          idx = idx - (PW+1)'(N);
        end
        if (!found && i_req[idx[PW-1:0]]) begin
          found   = 1'b1;
          gnt_idx = idx[PW-1:0];
        end
      end
      if (found) begin
        o_grant[gnt_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prio <= '0;
    end else if (found) begin
      prio <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end

  grant_onehot0 : assert property (@(posedge i_clk) $onehot0(o_grant));
  grant_valid   : assert property (@(posedge i_clk) (o_grant & ~i_req) == '0);

endmodule

// File: rtl/gpr_writeback_arbiter.sv
// Shares the GPR write port among writeback requesters (round-robin) and keeps
// a pending-write scoreboard for RAW stalls in the issue stage.
module gpr_writeback_arbiter
  import core_pkg::*;
#(
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned XLEN    = core_pkg::XLEN,
  parameter int unsigned L2_NREG = core_pkg::L2_NREG
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [N_REQ-1:0]                  i_req_valid,
  input  logic [N_REQ-1:0][L2_NREG-1:0]     i_req_sel,
  input  logic [N_REQ-1:0][XLEN-1:0]        i_req_data,
  output logic [N_REQ-1:0]                  o_req_ready,
  output logic                              o_load_gpr,
  output logic [L2_NREG-1:0]                o_load_gpr_sel,
  output logic [XLEN-1:0]                   o_load_gpr_data,
  input  logic                              i_reserve,
  input  logic [L2_NREG-1:0]                i_reserve_sel,
  output logic [(1 << L2_NREG)-1:0]         o_busy
);

  localparam int unsigned NR = 1 << L2_NREG;

  wb_req_t             reqs [N_REQ];
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    grant;
  logic                hs;
  logic [L2_NREG-1:0]  win_sel;
  logic [XLEN-1:0]     win_data;
  logic [NR-1:0]       busy_nxt;

  // Bundle the flat requester ports into request records.
  always_comb begin
    for (int unsigned k = 0; k < N_REQ; k++) begin
      reqs[k].valid = i_req_valid[k];
      reqs[k].sel   = core_pkg::L2_NREG'(i_req_sel[k]);
      reqs[k].data  = core_pkg::XLEN'(i_req_data[k]);
      req_valid[k]  = reqs[k].valid;
    end
  end

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_req   (req_valid),
    .o_grant (grant)
  );

  assign o_req_ready = grant;
  assign hs          = |grant;

  // Grant is one-hot, so an OR-reduction selects the winner's payload.
  always_comb begin
    win_sel  = '0;
    win_data = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        win_sel  = win_sel  | L2_NREG'(reqs[k].sel);
        win_data = win_data | XLEN'(reqs[k].data);
      end
    end
  end

  // Write port register; r0 writes complete the handshake but never strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_load_gpr      <= 1'b0;
      o_load_gpr_sel  <= '0;
      o_load_gpr_data <= '0;
    end else begin
      o_load_gpr <= hs && (win_sel != '0);
      if (hs) begin
        o_load_gpr_sel  <= win_sel;
        o_load_gpr_data <= win_data;
      end
    end
  end

  // Commit clears first, then a reservation sets, so set wins on a collision.
  always_comb begin
    busy_nxt = o_busy;
    if (o_load_gpr) begin
      busy_nxt[o_load_gpr_sel] = 1'b0;
    end
    if (i_reserve && (i_reserve_sel != '0)) begin
      busy_nxt[i_reserve_sel] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_busy <= '0;
    end else begin
      o_busy <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_gpr_writeback_arbiter.sv
// Bench for gpr_writeback_arbiter: directed table, corner sequences and
// random traffic checked against a cycle-level reference model.
module tb_gpr_writeback_arbiter;

  localparam int N = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     valid = '0;
  logic [N-1:0][4:0]  sel  = '0;
  logic [N-1:0][31:0] data = '0;
  logic             reserve = 1'b0;
  logic [4:0]       rsel = '0;

  logic [N-1:0]     ready;
  logic             load;
  logic [4:0]       load_sel;
  logic [31:0]      load_data;
  logic [31:0]      busy;

  gpr_writeback_arbiter #(.N_REQ(N), .XLEN(32), .L2_NREG(5)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_req_valid     (valid),
    .i_req_sel       (sel),
    .i_req_data      (data),
    .o_req_ready     (ready),
    .o_load_gpr      (load),
    .o_load_gpr_sel  (load_sel),
    .o_load_gpr_data (load_data),
    .i_reserve       (reserve),
    .i_reserve_sel   (rsel),
    .o_busy          (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_prio = 0;
  logic        m_load = 1'b0;
  logic [4:0]  m_sel  = '0;
  logic [31:0] m_data = '0;
  logic [31:0] m_busy = '0;
  logic [N-1:0] m_ready = '0;
  int          m_win = -1;
  logic [31:0] rf [32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Mid-cycle: compute expected grant, compare everything, record RF writes.
  task automatic sample();
    @(negedge clk);
    m_ready = '0;
    m_win   = -1;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_prio + i) % N;
        if (m_win < 0 && valid[k]) m_win = k;
      end
      if (m_win >= 0) m_ready[m_win] = 1'b1;
    end
    chk("ready", 64'(ready), 64'(m_ready));
    chk("load", 64'(load), 64'(m_load));
    if (m_load) begin
      chk("load_sel", 64'(load_sel), 64'(m_sel));
      chk("load_data", 64'(load_data), 64'(m_data));
    end
    chk("busy", 64'(busy), 64'(m_busy));
    if (load && !rst) rf[load_sel] = load_data;
  endtask

  // Clock edge: advance the model, then leave time for inputs to change.
  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_prio = 0; m_load = 1'b0; m_sel = '0; m_data = '0; m_busy = '0;
    end else begin
      if (m_load) m_busy[m_sel] = 1'b0;
      if (reserve && rsel != 0) m_busy[rsel] = 1'b1;
      if (m_win >= 0) begin
        m_load = (sel[m_win] != 0);
        m_sel  = sel[m_win];
        m_data = data[m_win];
        m_prio = (m_win + 1) % N;
      end else begin
        m_load = 1'b0;
      end
    end
    #1;
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic [4:0]   s0, s1, s2;
    logic [N-1:0] exp_ready;
    logic         exp_load;
    logic [4:0]   exp_sel;
  } vec_t;

  vec_t tbl [14];

  initial begin
    for (int r = 0; r < 32; r++) rf[r] = '0;
    for (int k = 0; k < N; k++) data[k] = 32'hDEADBEEF + 32'(k) - 32'd1;

    tbl[0]  = '{3'b111, 5'd5, 5'd6, 5'd7, 3'b001, 1'b0, 5'd0};
    tbl[1]  = '{3'b111, 5'd5, 5'd6, 5'd7, 3'b010, 1'b1, 5'd5};
    tbl[2]  = '{3'b111, 5'd5, 5'd6, 5'd7, 3'b100, 1'b1, 5'd6};
    tbl[3]  = '{3'b111, 5'd5, 5'd6, 5'd7, 3'b001, 1'b1, 5'd7};
    tbl[4]  = '{3'b111, 5'd5, 5'd6, 5'd7, 3'b010, 1'b1, 5'd5};
    tbl[5]  = '{3'b111, 5'd5, 5'd6, 5'd7, 3'b100, 1'b1, 5'd6};
    tbl[6]  = '{3'b000, 5'd5, 5'd6, 5'd7, 3'b000, 1'b1, 5'd7};
    tbl[7]  = '{3'b000, 5'd5, 5'd6, 5'd7, 3'b000, 1'b0, 5'd0};
    tbl[8]  = '{3'b110, 5'd5, 5'd6, 5'd7, 3'b010, 1'b0, 5'd0};
    tbl[9]  = '{3'b101, 5'd5, 5'd6, 5'd7, 3'b100, 1'b1, 5'd6};
    tbl[10] = '{3'b001, 5'd5, 5'd6, 5'd7, 3'b001, 1'b1, 5'd7};
    tbl[11] = '{3'b000, 5'd5, 5'd6, 5'd7, 3'b000, 1'b1, 5'd5};
    tbl[12] = '{3'b010, 5'd5, 5'd0, 5'd7, 3'b010, 1'b0, 5'd0};
    tbl[13] = '{3'b000, 5'd5, 5'd6, 5'd7, 3'b000, 1'b0, 5'd0};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reserve every register, then reset clears the whole scoreboard.
    for (int r = 1; r < 32; r++) begin
      reserve = 1'b1; rsel = 5'(r);
      sample(); advance();
    end
    reserve = 1'b0;
    sample();
    chk("busy_all", 64'(busy), 64'hFFFF_FFFE);
    advance();
    rst = 1'b1; valid = 3'b111;
    sel[0] = 5'd5; sel[1] = 5'd6; sel[2] = 5'd7;
    sample();
    chk("ready_in_rst", 64'(ready), 64'd0);
    advance();
    rst = 1'b0; valid = '0;
    sample();
    chk("busy_after_rst", 64'(busy), 64'd0);
    chk("load_after_rst", 64'(load), 64'd0);
    advance();

    // Rotation, skip, and r0-drop vectors
    for (int i = 0; i < 14; i++) begin
      valid = tbl[i].valid;
      sel[0] = tbl[i].s0; sel[1] = tbl[i].s1; sel[2] = tbl[i].s2;
      sample();
      chk($sformatf("tbl%0d_ready", i), 64'(ready), 64'(tbl[i].exp_ready));
      chk($sformatf("tbl%0d_load", i), 64'(load), 64'(tbl[i].exp_load));
      if (tbl[i].exp_load) chk($sformatf("tbl%0d_sel", i), 64'(load_sel), 64'(tbl[i].exp_sel));
      advance();
    end

    // Scoreboard: reserve r3, commit r3=0x1234.
    valid = '0; reserve = 1'b1; rsel = 5'd3;
    sample(); advance();
    reserve = 1'b0; valid = 3'b001; sel[0] = 5'd3; data[0] = 32'h1234;
    sample();
    chk("r3_busy_pre", 64'(busy[3]), 64'd1);
    chk("r3_ready", 64'(ready), 64'b001);
    advance();
    valid = '0;
    sample();
    chk("r3_load", 64'(load), 64'd1);
    chk("r3_busy_commit", 64'(busy[3]), 64'd1);
    advance();
    sample();
    chk("r3_busy_post", 64'(busy[3]), 64'd0);
    chk("r3_rf", 64'(rf[3]), 64'h1234);
    advance();

    // Reserve r9 in the same cycle its write commits: stays busy.
    valid = 3'b001; sel[0] = 5'd9; data[0] = 32'h9999;
    sample(); advance();
    valid = '0; reserve = 1'b1; rsel = 5'd9;
    sample();
    chk("r9_load_sel", 64'(load_sel), 64'd9);
    advance();
    reserve = 1'b0;
    sample();
    chk("r9_busy", 64'(busy[9]), 64'd1);
    advance();

    // Reset between handshake and commit drops the r4 write.
    valid = 3'b001; sel[0] = 5'd4; data[0] = 32'h4444;
    sample(); advance();
    valid = '0; rst = 1'b1;
    sample();
    chk("r4_load_reg", 64'(load), 64'd1);
    advance();
    rst = 1'b0;
    sample();
    chk("r4_load_dropped", 64'(load), 64'd0);
    chk("r4_rf", 64'(rf[4]), 64'd0);
    advance();

    // Random traffic; ungranted requesters keep their payload.
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < N; k++) begin
        if (valid[k] && !m_ready[k]) begin
          valid[k] = ($urandom_range(0, 3) != 0);
        end else begin
          valid[k] = ($urandom_range(0, 2) != 0);
          sel[k]   = 5'($urandom_range(0, 31));
          data[k]  = $urandom;
        end
      end
      reserve = ($urandom_range(0, 1) != 0);
      rsel    = 5'($urandom_range(0, 31));
      rst     = ($urandom_range(0, 63) == 0);
      sample(); advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
